// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared definitions for the gray_counter_n family: direction
//               encodings and width-generic binary/Gray conversion helpers.
//               The helpers operate on a 16-bit container (the widest legal
//               counter); narrower values are zero-extended by the caller.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

    localparam int   c_MAX_WIDTH = 16;

    // Direction encodings sampled on Dir
    localparam logic DIR_UP      = 1'b1;
    localparam logic DIR_DOWN    = 1'b0;

    // Binary to Gray: each Gray bit is the XOR of adjacent binary bits
    function automatic logic [c_MAX_WIDTH-1:0] bin2gray(input logic [c_MAX_WIDTH-1:0] b);
        logic [c_MAX_WIDTH-1:0] g;
        g[c_MAX_WIDTH-1] = b[c_MAX_WIDTH-1];
        for (int i = c_MAX_WIDTH - 2; i >= 0; i--) begin
            g[i] = b[i+1] ^ b[i];
        end
        return g;
    endfunction

    // Gray to binary: each binary bit is the running XOR from the MSB down
    function automatic logic [c_MAX_WIDTH-1:0] gray2bin(input logic [c_MAX_WIDTH-1:0] g);
        logic [c_MAX_WIDTH-1:0] b;
        b[c_MAX_WIDTH-1] = g[c_MAX_WIDTH-1];
        for (int i = c_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_conv.sv
`default_nettype none
// ============================================================================
// Module      : gray_conv
// Description : Purely combinational WIDTH-bit binary to Gray conversion.
//               Used on the counter's next-state value so the Gray output can
//               be registered directly.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_conv #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Adjacent-bit XOR; the MSB passes through unchanged
    assign gray = bin ^ (bin >> 1);

endmodule : gray_conv
`default_nettype wire

// File: rtl/gray_counter_n.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter_n
// Description : Parametrised Gray-code up/down counter with synchronous clear
//               and load, sticky Overflow/Underflow flags and a one-cycle Wrap
//               pulse. Both the binary and the Gray count are held in flops so
//               Output never comes from combinational logic.
//               Build option: GRAY_CNT_SATURATE_EN - when defined the counter
//               saturates at its terminal values instead of wrapping and Wrap
//               is never asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int INIT  = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Bin,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] c_INIT_BIN  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] c_INIT_GRAY = WIDTH'(bin2gray(c_MAX_WIDTH'(c_INIT_BIN)));
    localparam logic [WIDTH-1:0] c_TOP       = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_BOTTOM    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_ovf;
    logic             r_unf;
    logic             r_wrap;

    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_ovf_next;
    logic             w_unf_next;
    logic             w_wrap_next;

    // Next-state selection with priority Clr > Load > En
    always_comb begin
        w_bin_next  = r_bin;
        w_ovf_next  = r_ovf;
        w_unf_next  = r_unf;
        w_wrap_next = 1'b0;
        if (Clr) begin
            w_bin_next = c_INIT_BIN;
            w_ovf_next = 1'b0;
            w_unf_next = 1'b0;
        end else if (Load) begin
            // A load is never a wrap, even to a terminal value
            w_bin_next = LoadValue;
        end else if (En) begin
            if (Dir == DIR_UP) begin
                if (r_bin == c_TOP) begin
                    w_ovf_next = 1'b1;
`ifdef GRAY_CNT_SATURATE_EN
                    w_bin_next = r_bin;
`else
                    w_bin_next  = c_BOTTOM;
                    w_wrap_next = 1'b1;
`endif
                end else begin
                    w_bin_next = r_bin + c_ONE;
                end
            end else begin
                if (r_bin == c_BOTTOM) begin
                    w_unf_next = 1'b1;
`ifdef GRAY_CNT_SATURATE_EN
                    w_bin_next = r_bin;
`else
                    w_bin_next  = c_TOP;
                    w_wrap_next = 1'b1;
`endif
                end else begin
                    w_bin_next = r_bin - c_ONE;
                end
            end
        end
    end

    // Gray image of the next count, registered alongside the binary count
    gray_conv #(
        .WIDTH (WIDTH)
    ) u_gray_conv (
        .bin  (w_bin_next),
        .gray (w_gray_next)
    );

    // State registers; reset is asynchronous and overrides every other input
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_bin  <= c_INIT_BIN;
            r_gray <= c_INIT_GRAY;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_ovf  <= w_ovf_next;
            r_unf  <= w_unf_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign Output    = r_gray;
    assign Bin       = r_bin;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;
    assign Wrap      = r_wrap;

endmodule : gray_counter_n
`default_nettype wire

// File: tb/tb_gray_counter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_counter_n
// Description : Self-checking bench for gray_counter_n (WIDTH=3, INIT=0).
//               A driver issues one stimulus per cycle and queues the
//               hand-computed response; a monitor pops and compares it after
//               the following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter_n;

    typedef struct packed {
        logic [2:0] g;
        logic [2:0] b;
        logic       ovf;
        logic       unf;
        logic       wrap;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       En, Dir, Clr, Load;
    logic [2:0] LoadValue;
    logic [2:0] Output, Bin;
    logic       Overflow, Underflow, Wrap;

    exp_t       q_exp[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         n_step  = 0;

    gray_counter_n #(
        .WIDTH (3),
        .INIT  (0)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .En        (En),
        .Dir       (Dir),
        .Clr       (Clr),
        .Load      (Load),
        .LoadValue (LoadValue),
        .Output    (Output),
        .Bin       (Bin),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .Wrap      (Wrap)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s[%0d] actual=%0b required=%0b", name, idx, act, req);
    endtask

    // Drive one cycle of stimulus and queue its expected result
    task automatic step(input logic en, input logic dir, input logic clr, input logic load,
                        input logic [2:0] lv, input logic [2:0] g, input logic [2:0] b,
                        input logic ovf, input logic unf, input logic wrap);
        exp_t e;
        @(negedge Clk);
        En = en; Dir = dir; Clr = clr; Load = load; LoadValue = lv;
        e.g = g; e.b = b; e.ovf = ovf; e.unf = unf; e.wrap = wrap;
        q_exp.push_back(e);
    endtask

    task automatic drain();
        int budget = 10;
        while (q_exp.size() != 0 && budget > 0) begin
            @(posedge Clk);
            #2;
            budget--;
        end
        n_total++;
        if (q_exp.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d required=0 pending", q_exp.size());
    endtask

    // Monitor: after every rising edge compare the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                chk("Output",    n_step, Output,    e.g);
                chk("Bin",       n_step, Bin,       e.b);
                chk("Overflow",  n_step, Overflow,  e.ovf);
                chk("Underflow", n_step, Underflow, e.unf);
                chk("Wrap",      n_step, Wrap,      e.wrap);
                n_step++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; En = 1'b0; Dir = 1'b1; Clr = 1'b0; Load = 1'b0; LoadValue = 3'd0;
        #3;
        chk("rst_Output", 0, Output, 3'b000);
        chk("rst_Bin",    0, Bin,    3'd0);
        chk("rst_flags",  0, {Overflow, Underflow, Wrap}, 3'b000);
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b1;

`ifndef GRAY_CNT_SATURATE_EN
        // Full up sequence wrapping from 7 to 0
        step(1, 1, 0, 0, 0, 3'b001, 3'd1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b011, 3'd2, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b010, 3'd3, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b110, 3'd4, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b111, 3'd5, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b101, 3'd6, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b100, 3'd7, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b000, 3'd0, 1, 0, 1);
        // Hold keeps sticky flag, drops Wrap
        step(0, 1, 0, 0, 0, 3'b000, 3'd0, 1, 0, 0);
        // Clr beats Load and clears Overflow
        step(0, 1, 1, 1, 5, 3'b000, 3'd0, 0, 0, 0);
        // Down across zero
        step(1, 0, 0, 0, 0, 3'b100, 3'd7, 0, 1, 1);
        step(1, 0, 0, 0, 0, 3'b101, 3'd6, 0, 1, 0);
        // Load keeps flags
        step(0, 0, 0, 1, 5, 3'b111, 3'd5, 0, 1, 0);
        // Direction change with no dead cycle
        step(1, 1, 0, 0, 0, 3'b101, 3'd6, 0, 1, 0);
        step(1, 0, 0, 0, 0, 3'b111, 3'd5, 0, 1, 0);
        // Load of terminal value is not a wrap; next up is
        step(1, 1, 0, 1, 7, 3'b100, 3'd7, 0, 1, 0);
        step(1, 1, 0, 0, 0, 3'b000, 3'd0, 1, 1, 1);
        step(1, 1, 0, 0, 0, 3'b001, 3'd1, 1, 1, 0);
`else
        // Saturating: hold at top and bottom, never Wrap
        step(0, 1, 0, 1, 7, 3'b100, 3'd7, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b100, 3'd7, 1, 0, 0);
        step(1, 1, 0, 0, 0, 3'b100, 3'd7, 1, 0, 0);
        step(1, 1, 0, 0, 0, 3'b100, 3'd7, 1, 0, 0);
        step(1, 0, 0, 0, 0, 3'b101, 3'd6, 1, 0, 0);
        step(0, 0, 0, 1, 0, 3'b000, 3'd0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 3'b000, 3'd0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 3'b000, 3'd0, 1, 1, 0);
        step(1, 1, 0, 0, 0, 3'b001, 3'd1, 1, 1, 0);
`endif
        // Clear, then count up to 4 (Gray 110)
        step(0, 1, 1, 0, 0, 3'b000, 3'd0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b001, 3'd1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b011, 3'd2, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b010, 3'd3, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b110, 3'd4, 0, 0, 0);
        drain();

        // Asynchronous reset mid-cycle while still enabled
        #1;
        Reset = 1'b0;
        #1;
        chk("async_Output", 1, Output, 3'b000);
        chk("async_Bin",    1, Bin,    3'd0);
        chk("async_flags",  1, {Overflow, Underflow, Wrap}, 3'b000);
        @(negedge Clk);
        En = 1'b0;
        Reset = 1'b1;
        step(1, 1, 0, 0, 0, 3'b001, 3'd1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3'b011, 3'd2, 0, 0, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_gray_counter_n
`default_nettype wire
